// File: rtl/mul_div_unit_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package MulDivPkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdOpE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP
  } mdStateE;

  // Per-operation control captured alongside the operands.
  typedef struct packed {
    mdOpE op;
    logic negRes;   // negate product / quotient in FIXUP
    logic negRem;   // negate remainder in FIXUP
    logic divZero;
  } mdCtrlS;

  function automatic logic isSigned(mdOpE op);
    return op[0];
  endfunction

  function automatic logic isDivide(mdOpE op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_addsub.sv
// Generic adder/subtractor: op=0 adds, op=1 subtracts; carryOut=1 on subtract means no borrow.
module AdderSubtractor #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            op,
  output logic [BITS-1:0] result,
  output logic            carryOut
);

  logic [BITS:0] full;

  assign full     = {1'b0, a} + {1'b0, (op ? ~b : b)} + {{BITS{1'b0}}, op};
  assign result   = full[BITS-1:0];
  assign carryOut = full[BITS];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply (shift-add) and restoring divide, WIDTH CALC cycles plus one FIXUP.
module mul_div_unit
  import MulDivPkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdStateE            state, stateNext;
  logic [CW-1:0]      cnt;
  mdCtrlS             ctrl;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operandB;

  mdOpE               reqOp;
  logic               signA, signB, lastIter;
  logic [WIDTH-1:0]   magA, magB;

  assign reqOp    = mdOpE'(op);
  assign signA    = isSigned(reqOp) & a[WIDTH-1];
  assign signB    = isSigned(reqOp) & b[WIDTH-1];
  assign magA     = signA ? -a : a;
  assign magB     = signB ? -b : b;
  assign lastIter = (cnt == CW'(WIDTH - 1));
  assign busy     = (state != ST_IDLE);

  // Multiply step: add multiplicand into the upper half, keeping the carry for the shift.
  logic [WIDTH:0] mulSum;
  assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operandB};

  // Divide step: acc = {remainder, dividend bits still to shift in}.
  logic [WIDTH:0] shifted, diff;
  logic           noBorrow, qBit;
  assign shifted = acc[2*WIDTH-1:WIDTH-1];

  AdderSubtractor #(.BITS(WIDTH + 1)) uSub (
    .a        (shifted),
    .b        ({1'b0, operandB}),
    .op       (1'b1),
    .result   (diff),
    .carryOut (noBorrow)
  );

  assign qBit = noBorrow & ~diff[WIDTH];

  logic [2*WIDTH-1:0] prodNeg;
  logic [WIDTH-1:0]   quoNeg, remNeg;
  assign prodNeg = -acc;
  assign quoNeg  = -acc[WIDTH-1:0];
  assign remNeg  = -acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= ST_IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (flush) begin
      stateNext = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start)    stateNext = ST_CALC;
        ST_CALC:  if (lastIter) stateNext = ST_FIXUP;
        ST_FIXUP: stateNext = ST_IDLE;
        default:  stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt       <= '0;
      ctrl      <= '0;
      acc       <= '0;
      operandB  <= '0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            cnt          <= '0;
            acc          <= {{WIDTH{1'b0}}, magA};
            operandB     <= magB;
            ctrl.op      <= reqOp;
            ctrl.negRes  <= signA ^ signB;
            ctrl.negRem  <= signA;
            ctrl.divZero <= isDivide(reqOp) && (b == '0);
          end
          ST_CALC: begin
            cnt <= cnt + CW'(1);
            if (isDivide(ctrl.op))
              acc <= {(qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], qBit};
            else if (acc[0])
              acc <= {mulSum, acc[WIDTH-1:1]};
            else
              acc <= {1'b0, acc[2*WIDTH-1:1]};
          end
          ST_FIXUP: begin
            done      <= 1'b1;
            divByZero <= ctrl.divZero;
            if (isDivide(ctrl.op)) begin
              // With b=0 the remainder already holds |a|, so the sign fix restores a.
              lo <= ctrl.divZero ? '1 : (ctrl.negRes ? quoNeg : acc[WIDTH-1:0]);
              hi <= ctrl.negRem ? remNeg : acc[2*WIDTH-1:WIDTH];
            end else begin
              {hi, lo} <= ctrl.negRes ? prodNeg : acc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: MulDivUnit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits (WIDTH >= 4).
REQ-002 SHALL have clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-003 SHALL have nReset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have start, input, 1 bit, which requests an operation; it is sampled only while busy=0.
REQ-005 SHALL have op, input, 2 bits, selecting the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; it is sampled with start.
REQ-006 SHALL have a, input, WIDTH bits, the multiplicand or dividend, sampled with start.
REQ-007 SHALL have b, input, WIDTH bits, the multiplier or divisor, sampled with start.
REQ-008 SHALL have flush, input, 1 bit, a synchronous abort of any operation in progress.
REQ-009 SHALL have busy, output, 1 bit, high from the cycle after an accepted start until done.
REQ-010 SHALL have done, output, 1 bit, a one-cycle completion pulse.
REQ-011 SHALL have hi, output, WIDTH bits: the upper product half, or the remainder.
REQ-012 SHALL have lo, output, WIDTH bits: the lower product half, or the quotient.
REQ-013 SHALL have divByZero, output, 1 bit, which pulses together with done when a division had b=0.

Function
REQ-014 SHALL use a state machine with three states:
- IDLE
- CALC (exactly WIDTH iterations)
- FIXUP (1 cycle, sign correction and output load)
REQ-015 SHALL leave IDLE for CALC on the edge where start=1, flush=0 and busy=0, capturing op, a and b.
REQ-016 SHALL ignore start while busy=1; no operands are re-captured.
REQ-017 SHALL, in MULT and DIV modes, take the operand magnitudes (two's-complement absolute value) at capture and record the result signs.
REQ-018 SHALL compute multiply as radix-2 shift-add over a 2*WIDTH accumulator, one bit per CALC cycle.
REQ-019 SHALL compute divide as restoring radix-2 division, one quotient bit per CALC cycle, using a WIDTH+1-bit subtract.
REQ-020 SHALL, in FIXUP, negate the results as needed and load hi/lo, with done=1 in the cycle after the FIXUP edge.
- Total latency: done is high in cycle N+WIDTH+2, where the capture edge ends cycle N.
REQ-021 SHALL make the product {hi,lo} exact at 2*WIDTH bits for both MULT and MULTU.
REQ-022 SHALL truncate the signed quotient toward zero and give the remainder the sign of the dividend.
REQ-023 SHALL, for signed division of the most negative value by -1, give lo = the most negative value and hi = 0, with no flag.
REQ-024 SHALL, on b=0 in a divide, give hi=a and lo=all ones, pulse divByZero with done, and keep the full latency.
REQ-025 SHALL hold hi/lo from the last completed operation until the next FIXUP; they are unchanged during CALC.
REQ-026 SHALL, on flush=1, return to IDLE on that edge with busy=0, no done pulse and hi/lo unchanged; flush has priority over start.
REQ-027 SHALL accept a new start in the same cycle that done=1 (back-to-back operation).

Reset
REQ-028 SHALL, while nReset=0, force state=IDLE, busy=0, done=0, divByZero=0, hi=0, lo=0 and clear the iteration counter, regardless of the clock.
REQ-029 SHALL abandon an operation interrupted by reset with no done pulse, and accept start on the first edge after release.

Structure
REQ-030 SHALL define the op encoding enum, the state enum and the op-decode helpers (isSigned, isDivide) in shared package MulDivPkg.
REQ-031 SHALL implement the iteration counter as $clog2(WIDTH)+1 bits, derived from WIDTH.
REQ-032 SHALL implement the per-cycle divide subtract as one instance of the team's AdderSubtractor with BITS=WIDTH+1 and op=1.

Verification
REQ-033 SHALL verify, at WIDTH=32: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, with done exactly 34 cycles after the start cycle.
REQ-034 SHALL verify: MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 SHALL verify:
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, divByZero=0.
REQ-036 SHALL verify: DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, divByZero=1 for one cycle together with done.
REQ-037 SHALL verify: start pulsed again at cycle 10 of a MULTU -> ignored, first result intact; flush at cycle 10 -> busy=0 next cycle, no done, hi/lo keep prior values.
REQ-038 SHALL verify: nReset asserted mid-DIV -> all outputs 0 immediately; a new start after release -> correct result with normal latency.
